// File: rtl/relu_maxpool_stage.sv
// relu_maxpool_stage
//   This block takes a raster-order stream of signed convolution results. It
//   applies ReLU, then 2x2 stride-2 max-pooling. It shifts the pooled value
//   right by SHIFT and saturates it to an unsigned OUT_W-bit pixel.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      one-cycle pulse; arms a new frame (ignored outside IDLE)
//   in_valid   conv result valid
//   in_data    signed conv result (two's complement)
//   in_ready   block accepts in_data this cycle
//   out_valid  pooled pixel valid
//   out_data   pooled, requantized pixel
//   out_ready  downstream accepts out_data
//   frame_done one-cycle pulse in the cycle the frame finishes draining
//   sat_count  (SAT_COUNT_EN only) saturated outputs in the current frame
//
// Optional feature macro: SAT_COUNT_EN (adds sat_count).
module relu_maxpool_stage #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8,
  parameter int MAP_W  = 3,
  parameter int MAP_H  = 3,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     frame_done
`ifdef SAT_COUNT_EN
  ,
  output logic [7:0]               sat_count
`endif
);

  localparam int MAG_W     = DATA_W - 1;
  localparam int COL_W     = $clog2(MAP_W);
  localparam int ROW_W     = $clog2(MAP_H);
  localparam int BUF_DEPTH = MAP_W / 2;
  localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [MAG_W-1:0] OUT_MAX = MAG_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [MAG_W-1:0]  held;
  // Sized to a power of two so the index width matches the array exactly;
  // only the first BUF_DEPTH entries are ever addressed.
  logic [MAG_W-1:0]  row_buf [0:(1 << BUF_AW)-1];
  logic [BUF_AW-1:0] buf_idx;

  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             load;
  logic [MAG_W-1:0] relu;
  logic [MAG_W-1:0] pm;
  logic [MAG_W-1:0] bv;
  logic [MAG_W-1:0] p;
  logic [MAG_W-1:0] q;
  logic             over;
  logic [OUT_W-1:0] pix;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && col_last && row_last) state_next = DRAIN;
      DRAIN:   if (!out_valid || out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == RUN) && !(out_valid && !out_ready);
    frame_done = (state == DRAIN) && (!out_valid || out_ready);
  end

  // ------------------------------------------------------------ datapath
  always_comb begin
    accept   = in_valid && in_ready;
    col_last = (col == COL_W'(MAP_W - 1));
    row_last = (row == ROW_W'(MAP_H - 1));
    buf_idx  = BUF_AW'(col >> 1);
    relu     = in_data[DATA_W-1] ? '0 : in_data[MAG_W-1:0];
    pm       = (held > relu) ? held : relu;
    bv       = row_buf[buf_idx];
    p        = (bv > pm) ? bv : pm;
    q        = p >> SHIFT;
    over     = (q > OUT_MAX);
    pix      = over ? '1 : q[OUT_W-1:0];
    // With an odd MAP_W the trailing even column never reaches an odd column.
    // With an odd MAP_H the trailing row is even. So discarded samples never
    // produce an output.
    load     = accept && col[0] && row[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state == IDLE && start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (load) begin
        out_data  <= pix;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Pair-hold register and row buffer carry no reset: every value is written
  // before it is read within a frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!col[0]) held <= relu;
      else if (!row[0]) row_buf[buf_idx] <= pm;
    end
  end

`ifdef SAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (state == IDLE && start) begin
      sat_count <= '0;
    end else if (load && over && sat_count != 8'hFF) begin
      sat_count <= sat_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_relu_maxpool_stage.sv
module tb_relu_maxpool_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               start_s      [3];
  logic               in_valid_s   [3];
  logic signed [15:0] in_data_s    [3];
  logic               in_ready_s   [3];
  logic               out_valid_s  [3];
  logic [7:0]         out_data_s   [3];
  logic               out_ready_s  [3];
  logic               frame_done_s [3];
`ifdef SAT_COUNT_EN
  logic [7:0]         sat_s        [3];
`endif

  // u0: 4x4 SHIFT=0, u1: 3x3 SHIFT=0, u2: 3x3 SHIFT=1
  relu_maxpool_stage #(.DATA_W(16), .OUT_W(8), .MAP_W(4), .MAP_H(4), .SHIFT(0)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_data(in_data_s[0]), .in_ready(in_ready_s[0]), .out_valid(out_valid_s[0]),
    .out_data(out_data_s[0]), .out_ready(out_ready_s[0]), .frame_done(frame_done_s[0])
`ifdef SAT_COUNT_EN
    , .sat_count(sat_s[0])
`endif
  );

  relu_maxpool_stage #(.DATA_W(16), .OUT_W(8), .MAP_W(3), .MAP_H(3), .SHIFT(0)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_data(in_data_s[1]), .in_ready(in_ready_s[1]), .out_valid(out_valid_s[1]),
    .out_data(out_data_s[1]), .out_ready(out_ready_s[1]), .frame_done(frame_done_s[1])
`ifdef SAT_COUNT_EN
    , .sat_count(sat_s[1])
`endif
  );

  relu_maxpool_stage #(.DATA_W(16), .OUT_W(8), .MAP_W(3), .MAP_H(3), .SHIFT(1)) u2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .in_valid(in_valid_s[2]),
    .in_data(in_data_s[2]), .in_ready(in_ready_s[2]), .out_valid(out_valid_s[2]),
    .out_data(out_data_s[2]), .out_ready(out_ready_s[2]), .frame_done(frame_done_s[2])
`ifdef SAT_COUNT_EN
    , .sat_count(sat_s[2])
`endif
  );

  int checks = 0;
  int errors = 0;
  int acc    [3];
  int fd_cnt [3];
  int fd_acc [3];
  int q0[$];
  int q1[$];
  int q2[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int v);
    case (d)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int pop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Watches one instance: counts accepted samples and frame_done pulses,
  // and checks every accepted output against the scoreboard.
  task automatic monitor(input int d);
    forever begin
      @(negedge clk);
      if (reset && in_valid_s[d] && in_ready_s[d]) acc[d]++;
      if (reset && frame_done_s[d]) begin
        fd_cnt[d]++;
        fd_acc[d] = acc[d];
      end
      if (reset && out_valid_s[d] && out_ready_s[d]) begin
        check($sformatf("sb_nonempty%0d", d), 32'(qsize(d) != 0), 1);
        if (qsize(d) != 0) check($sformatf("out_data%0d", d), 32'(out_data_s[d]), pop(d));
      end
    end
  endtask

  task automatic send(input int d, input int v);
    int n;
    in_valid_s[d] = 1'b1;
    in_data_s[d]  = 16'(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_s[d] && n < 100);
    if (n >= 100) check("in_ready_timeout", 32'(in_ready_s[d]), 1);
    @(posedge clk);
    #1;
    in_valid_s[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
  endtask

  task automatic frame(input int d, input int vals[$]);
    pulse_start(d);
    foreach (vals[i]) send(d, vals[i]);
  endtask

  // Bounded wait for the frame_done pulse, then confirm it happened once,
  // after the expected number of accepted samples, with the input closed.
  task automatic finish_frame(input int d, input int fd_before, input int acc_before,
                              input int n_samples, input string tag);
    int n;
    n = 0;
    while (fd_cnt[d] == fd_before && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_frame_done_once"}, 32'(fd_cnt[d] - fd_before), 1);
    check({tag, "_acc_at_done"}, 32'(fd_acc[d] - acc_before), 32'(n_samples));
    check({tag, "_in_ready_after"}, 32'(in_ready_s[d]), 0);
    check({tag, "_sb_drained"}, 32'(qsize(d)), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[$];
    int a, f, n;

    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i]     = 1'b0;
      in_valid_s[i]  = 1'b0;
      in_data_s[i]   = '0;
      out_ready_s[i] = 1'b1;
      acc[i]    = 0;
      fd_cnt[i] = 0;
      fd_acc[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_s[0]), 0);
    check("rst_out_data", 32'(out_data_s[0]), 0);
    check("rst_in_ready", 32'(in_ready_s[0]), 0);
    check("rst_frame_done", 32'(frame_done_s[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // Ramp 1..16 on 4x4.
    vals = {};
    for (int i = 1; i <= 16; i++) vals.push_back(i);
    push(0, 6); push(0, 8); push(0, 14); push(0, 16);
    a = acc[0]; f = fd_cnt[0];
    frame(0, vals);
    finish_frame(0, f, a, 16, "ramp");

    // All negative values: ReLU must produce zeros.
    vals = {};
    for (int i = 1; i <= 16; i++) vals.push_back((i == 6) ? -1 : -50);
    repeat (4) push(0, 0);
    a = acc[0]; f = fd_cnt[0];
    frame(0, vals);
    finish_frame(0, f, a, 16, "neg");

    // Default 3x3 with a saturating value.
    vals = '{300, 2, 9, 4, 5, 6, 7, 8, 9};
    push(1, 255);
    a = acc[1]; f = fd_cnt[1];
    frame(1, vals);
    finish_frame(1, f, a, 9, "sat3x3");
`ifdef SAT_COUNT_EN
    check("sat3x3_count", 32'(sat_s[1]), 1);
`endif

    // Same frame with SHIFT=1.
    push(2, 150);
    a = acc[2]; f = fd_cnt[2];
    frame(2, vals);
    finish_frame(2, f, a, 9, "shift3x3");
`ifdef SAT_COUNT_EN
    check("shift3x3_count", 32'(sat_s[2]), 0);
`endif

    // Backpressure: hold out_ready low for 10 cycles once the first pixel appears.
    vals = {};
    for (int i = 1; i <= 16; i++) vals.push_back(i);
    push(0, 6); push(0, 8); push(0, 14); push(0, 16);
    a = acc[0]; f = fd_cnt[0];
    out_ready_s[0] = 1'b0;
    fork
      frame(0, vals);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid_s[0] && n < 200);
        check("stall_valid_seen", 32'(out_valid_s[0]), 1);
        for (int k = 0; k < 10; k++) begin
          check("stall_out_data", 32'(out_data_s[0]), 6);
          check("stall_in_ready", 32'(in_ready_s[0]), 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready_s[0] = 1'b1;
      end
    join
    finish_frame(0, f, a, 16, "stall");

    // Abort a frame with reset after 7 samples, then run a clean frame.
    push(0, 6);
    pulse_start(0);
    for (int i = 1; i <= 7; i++) send(0, i);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_sb_drained", 32'(qsize(0)), 0);
    check("abort_out_valid", 32'(out_valid_s[0]), 0);
    check("abort_in_ready", 32'(in_ready_s[0]), 0);
    check("abort_out_data", 32'(out_data_s[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(0, 6); push(0, 8); push(0, 14); push(0, 16);
    a = acc[0]; f = fd_cnt[0];
    frame(0, vals);
    finish_frame(0, f, a, 16, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
